// File: rtl/ucsbece154_mem_pkg.sv
// Shared types and helpers for the burst-read memory model feeding the I-cache refill path.
package ucsbece154_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    T0_WAIT,
    GAP,
    BURST
  } state_t;

  localparam int unsigned WORD_BYTES          = 4;
  localparam int unsigned DEFAULT_BLOCK_WORDS = 4;
  localparam int unsigned OFFSET_BITS         = $clog2(DEFAULT_BLOCK_WORDS);

  // Offset within the block of burst word j; wrap selects critical-word-first ordering.
  function automatic int unsigned burst_offset(input int unsigned crit,
                                               input int unsigned j,
                                               input int unsigned block_words,
                                               input logic        wrap);
    if (wrap) return (crit + j) & (block_words - 1);
    return j & (block_words - 1);
  endfunction

endpackage

// File: rtl/ucsbece154_burst_seq.sv
// Burst sequencer: request FSM, first-word/inter-word delay counting and burst offset generation.
module ucsbece154_burst_seq
  import ucsbece154_mem_pkg::*;
#(
  parameter  int unsigned IDX_W       = 8,
  parameter  int unsigned BLOCK_WORDS = 4,
  parameter  int unsigned T0_DELAY    = 40,
  parameter  int unsigned TN_DELAY    = 0,
  parameter  int unsigned WRAP_MODE   = 0,
  localparam int unsigned OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [IDX_W-1:0] req_index,
  output logic             busy,
  output logic             issue,
  output logic [IDX_W-1:0] word_addr,
  output logic [OFF_W-1:0] offset
);

  localparam int unsigned DMAX = (T0_DELAY > TN_DELAY) ? T0_DELAY : TN_DELAY;
  localparam int unsigned DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
  localparam int unsigned WW   = OFF_W + 1;

  localparam logic [DW-1:0] T0_LAST   = DW'(T0_DELAY);
  localparam logic [DW-1:0] GAP_LAST  = (TN_DELAY > 0) ? DW'(TN_DELAY - 1) : '0;
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);

  state_t           state;
  state_t           after_issue;
  logic [DW-1:0]    dly;
  logic [WW-1:0]    word;
  logic [IDX_W-1:0] base;
  logic [OFF_W-1:0] crit;
  logic             last;

  always_comb begin
    issue = 1'b0;
    case (state)
      T0_WAIT: issue = (dly == T0_LAST);
      BURST:   issue = 1'b1;
      default: issue = 1'b0;
    endcase
  end

  assign offset      = OFF_W'(burst_offset(32'(crit), 32'(word), BLOCK_WORDS, WRAP_MODE != 0));
  assign word_addr   = base | IDX_W'(offset);
  assign last        = (word == LAST_WORD);
  assign after_issue = last ? IDLE : ((TN_DELAY > 0) ? GAP : BURST);

  // Busy is left untouched on the last-word edge so it stays high through that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dly   <= '0;
      word  <= '0;
      base  <= '0;
      crit  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= req;
          if (req) begin
            base  <= req_index & ~IDX_W'(BLOCK_WORDS - 1);
            crit  <= req_index[OFF_W-1:0];
            dly   <= '0;
            word  <= '0;
            state <= T0_WAIT;
          end
        end
        T0_WAIT: begin
          if (dly == T0_LAST) begin
            state <= after_issue;
            word  <= word + WW'(1);
            dly   <= '0;
          end else begin
            dly <= dly + DW'(1);
          end
        end
        GAP: begin
          if (dly == GAP_LAST) begin
            state <= BURST;
          end else begin
            dly <= dly + DW'(1);
          end
        end
        BURST: begin
          state <= after_issue;
          word  <= word + WW'(1);
          dly   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ucsbece154_burst_mem.sv
// SDRAM-style burst read memory: preloaded word array, sequencer and registered cache-side outputs.
module ucsbece154_burst_mem
  import ucsbece154_mem_pkg::*;
#(
  parameter int unsigned TEXT_SIZE   = 256,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned T0_DELAY    = 40,
  parameter int unsigned TN_DELAY    = 0,
  parameter int unsigned WRAP_MODE   = 0,
  parameter logic [31:0] INIT_BASE   = 32'h00000013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ReadRequest,
  input  logic [31:0]                    ReadAddress,
  output logic [31:0]                    DataIn,
  output logic                           DataReady,
  output logic [$clog2(BLOCK_WORDS)-1:0] WordIndex,
  output logic                           Busy
);

  localparam int unsigned IDX_W     = $clog2(TEXT_SIZE);
  localparam int unsigned OFF_W     = $clog2(BLOCK_WORDS);
  localparam int unsigned BYTE_BITS = $clog2(WORD_BYTES);

  logic [31:0]      mem [TEXT_SIZE];
  logic             issue;
  logic [IDX_W-1:0] word_addr;
  logic [OFF_W-1:0] offset;
  logic             unused_addr;

  // Contents are fixed from time zero and never written, so reset leaves them alone.
  for (genvar i = 0; i < TEXT_SIZE; i++) begin : g_init
    assign mem[i] = INIT_BASE + 32'(i);
  end

  // Byte-lane and above-depth address bits do not select a word.
  assign unused_addr = ^ReadAddress;

  ucsbece154_burst_seq #(
    .IDX_W       (IDX_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .T0_DELAY    (T0_DELAY),
    .TN_DELAY    (TN_DELAY),
    .WRAP_MODE   (WRAP_MODE)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .req       (ReadRequest),
    .req_index (ReadAddress[BYTE_BITS +: IDX_W]),
    .busy      (Busy),
    .issue     (issue),
    .word_addr (word_addr),
    .offset    (offset)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DataIn    <= '0;
      DataReady <= 1'b0;
      WordIndex <= '0;
    end else begin
      DataReady <= issue;
      if (issue) begin
        DataIn    <= mem[word_addr];
        WordIndex <= offset;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_burst_mem.sv
// Bench for ucsbece154_burst_mem: four timing/ordering configurations against a burst-schedule model.
`timescale 1ns/1ps
module tb_ucsbece154_burst_mem;

  localparam int NI = 4;
  // Per-instance configs, 8 bits each, instance 0 in the low byte.
  localparam logic [31:0] T0_P = {8'd0, 8'd0, 8'd3, 8'd40};
  localparam logic [31:0] TN_P = {8'd0, 8'd2, 8'd0, 8'd0};
  localparam logic [31:0] WR_P = {8'd1, 8'd0, 8'd1, 8'd0};
  localparam logic [31:0] INIT = 32'h13;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        rq   = 1'b0;
  logic [31:0] addr = '0;

  logic [31:0] di [NI];
  logic        dr [NI];
  logic [1:0]  wi [NI];
  logic        bz [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ucsbece154_burst_mem #(
      .TEXT_SIZE   (256),
      .BLOCK_WORDS (4),
      .T0_DELAY    (int'(T0_P[g*8 +: 8])),
      .TN_DELAY    (int'(TN_P[g*8 +: 8])),
      .WRAP_MODE   (int'(WR_P[g*8 +: 8])),
      .INIT_BASE   (INIT)
    ) dut (
      .clk         (clk),
      .reset       (rst),
      .ReadRequest (rq),
      .ReadAddress (addr),
      .DataIn      (di[g]),
      .DataReady   (dr[g]),
      .WordIndex   (wi[g]),
      .Busy        (bz[g])
    );
  end

  function automatic int unsigned t0(input int i); return int'(T0_P[i*8 +: 8]); endfunction
  function automatic int unsigned tn(input int i); return int'(TN_P[i*8 +: 8]); endfunction
  function automatic int unsigned wr(input int i); return int'(WR_P[i*8 +: 8]); endfunction

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  task automatic chk(input string what, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc %0d: got %h, expected %h", what, i, cyc, got, exp);
    end
  endtask

  // Model: a request accepted at edge k schedules word j at edge k+1+T0+j*(TN+1).
  bit          act   [NI];
  int unsigned first [NI];
  int unsigned mbase [NI];
  int unsigned mcrit [NI];
  logic [31:0] e_di  [NI];
  logic        e_dr  [NI];
  logic [1:0]  e_wi  [NI];
  logic        e_bz  [NI];

  always @(posedge clk or posedge rst) begin
    int unsigned c, j, o, widx;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        act[i]  <= 1'b0;
        e_di[i] <= '0;
        e_dr[i] <= 1'b0;
        e_wi[i] <= '0;
        e_bz[i] <= 1'b0;
      end
    end else begin
      c = cyc + 1;
      cyc <= c;
      widx = (addr >> 2) % 256;
      for (int i = 0; i < NI; i++) begin
        e_dr[i] <= 1'b0;
        if (act[i]) begin
          e_bz[i] <= 1'b1;
          if (c >= first[i] && (c - first[i]) % (tn(i) + 1) == 0) begin
            j = (c - first[i]) / (tn(i) + 1);
            o = (wr(i) != 0) ? (mcrit[i] + j) % 4 : j;
            e_dr[i] <= 1'b1;
            e_di[i] <= INIT + 32'(mbase[i] + o);
            e_wi[i] <= 2'(o);
            if (j == 3) act[i] <= 1'b0;
          end
        end else begin
          e_bz[i] <= rq;
          if (rq) begin
            act[i]   <= 1'b1;
            first[i] <= c + 1 + t0(i);
            mbase[i] <= (widx / 4) * 4;
            mcrit[i] <= widx % 4;
          end
        end
      end
    end
  end

  typedef struct {
    int          inst;
    int unsigned cyc;
    logic [31:0] d;
    logic [1:0]  w;
  } cap_t;
  cap_t cap [$];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("DataReady", i, 32'(dr[i]), 32'(e_dr[i]));
      chk("Busy",      i, 32'(bz[i]), 32'(e_bz[i]));
      chk("DataIn",    i, di[i],      e_di[i]);
      chk("WordIndex", i, 32'(wi[i]), 32'(e_wi[i]));
      if (dr[i] === 1'b1) cap.push_back('{i, cyc, di[i], wi[i]});
    end
  end

  function automatic bit any_busy();
    bit b = 1'b0;
    for (int i = 0; i < NI; i++) b |= (e_bz[i] | act[i]);
    return b;
  endfunction

  function automatic int unsigned ncap(input int i, input int unsigned lo, input int unsigned hi);
    int unsigned r = 0;
    foreach (cap[n]) if (cap[n].inst == i && cap[n].cyc >= lo && cap[n].cyc <= hi) r++;
    return r;
  endfunction

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (any_busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
    @(negedge clk);
  endtask

  task automatic request(input logic [31:0] a, output int unsigned k);
    @(negedge clk);
    rq   = 1'b1;
    addr = a;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    rq = 1'b0;
  endtask

  // Literal expectations: d/w packed with word 0 in the low lane.
  task automatic check_burst(input int i, input int unsigned k, input int unsigned lat,
                             input int unsigned step, input logic [127:0] d, input logic [7:0] w);
    cap_t got [$];
    foreach (cap[n])
      if (cap[n].inst == i && cap[n].cyc >= k && cap[n].cyc <= k + lat + 3 * step)
        got.push_back(cap[n]);
    chk("burst_len", i, got.size(), 4);
    for (int j = 0; j < 4 && j < got.size(); j++) begin
      chk("burst_cyc",  i, got[j].cyc - k,      lat + j * step);
      chk("burst_data", i, got[j].d,            d[j*32 +: 32]);
      chk("burst_idx",  i, 32'(got[j].w),       32'(w[j*2 +: 2]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned k, n0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_DataReady", i, 32'(dr[i]), 0);
      chk("rst_Busy",      i, 32'(bz[i]), 0);
      chk("rst_DataIn",    i, di[i],      0);
    end
    rst = 1'b0;
    @(negedge clk);

    request(32'h24, k);
    wait_idle(100);
    check_burst(0, k, 41, 1, {32'h1E, 32'h1D, 32'h1C, 32'h1B}, {2'd3, 2'd2, 2'd1, 2'd0});
    check_burst(1, k, 4,  1, {32'h1B, 32'h1E, 32'h1D, 32'h1C}, {2'd0, 2'd3, 2'd2, 2'd1});
    check_burst(2, k, 1,  3, {32'h1E, 32'h1D, 32'h1C, 32'h1B}, {2'd3, 2'd2, 2'd1, 2'd0});
    check_burst(3, k, 1,  1, {32'h1B, 32'h1E, 32'h1D, 32'h1C}, {2'd0, 2'd3, 2'd2, 2'd1});

    request(32'h0, k);
    wait_idle(100);
    check_burst(2, k, 1, 3, {32'h16, 32'h15, 32'h14, 32'h13}, {2'd3, 2'd2, 2'd1, 2'd0});

    request(32'h408, k);
    wait_idle(100);
    check_burst(0, k, 41, 1, {32'h16, 32'h15, 32'h14, 32'h13}, {2'd3, 2'd2, 2'd1, 2'd0});
    check_burst(1, k, 4,  1, {32'h14, 32'h13, 32'h16, 32'h15}, {2'd1, 2'd0, 2'd3, 2'd2});

    // Request held high: requests during a burst are dropped, not queued.
    @(negedge clk);
    rq   = 1'b1;
    addr = 32'h0;
    @(posedge clk);
    #1 k = cyc;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rq = 1'b0;
    wait_idle(100);
    chk("held_words", 3, ncap(3, k, k + 19), 16);
    chk("held_words", 1, ncap(1, k, k + 19), 8);
    chk("held_words", 2, ncap(2, k, k + 19), 7);
    chk("held_words", 0, ncap(0, k, k + 19), 0);

    // Async reset between edges while instance 1 presents its second word.
    request(32'h24, k);
    while (cyc < k + 5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("arst_DataReady", i, 32'(dr[i]), 0);
      chk("arst_Busy",      i, 32'(bz[i]), 0);
      chk("arst_DataIn",    i, di[i],      0);
      chk("arst_WordIndex", i, 32'(wi[i]), 0);
    end
    n0 = cap.size();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_reset_words", 0, cap.size() - n0, 0);
    request(32'h24, k);
    wait_idle(100);
    check_burst(0, k, 41, 1, {32'h1E, 32'h1D, 32'h1C, 32'h1B}, {2'd3, 2'd2, 2'd1, 2'd0});
    check_burst(1, k, 4,  1, {32'h1B, 32'h1E, 32'h1D, 32'h1C}, {2'd0, 2'd3, 2'd2, 2'd1});

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rq   = ($urandom_range(0, 99) < 30);
      addr = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    rq = 1'b0;
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154_burst_mem.md
Name: ucsbece154_burst_mem

Overview:
Parametrised SDRAM-style burst read memory model that feeds the instruction cache refill path. It accepts one block-read request at a time and waits a programmable first-word latency. It then streams BLOCK_WORDS words with a programmable inter-word gap. The burst is returned either in ascending order or critical-word-first with wrap-around. A busy flag and a word-offset tag let the cache place each word directly.

Parameters:
TEXT_SIZE, 256, memory depth in 32-bit words; power of 2.
BLOCK_WORDS, 4, words per burst; power of 2, at least 2; must match the cache line.
T0_DELAY, 40, idle cycles between request acceptance and the first word; at least 0.
TN_DELAY, 0, idle cycles between consecutive burst words; at least 0.
WRAP_MODE, 0, 0 = ascending from the block base; 1 = critical word first, wrapping within the block.
INIT_BASE, 32'h00000013, preload value; memory[i] = INIT_BASE + i.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
ReadRequest  input  1  block read request; sampled only in IDLE.
ReadAddress  input  32  byte address of the requested (critical) word.
DataIn  output  32  burst word (memory to cache).
DataReady  output  1  one-cycle strobe; DataIn and WordIndex are valid while it is high.
WordIndex  output  $clog2(BLOCK_WORDS)  offset within the block of the current DataIn.
Busy  output  1  high from the accept edge through the last-word cycle.

Behaviour:
- Reset is async, active-high; clk is the only clock. While reset is high, all outputs are 0 and state is IDLE; all counters clear.
- Reset mid-burst aborts the burst immediately; no further DataReady pulses for that request.
- Memory is preloaded at time 0 with INIT_BASE + i and is not modified by reset.
- Word index is (ReadAddress >> 2) mod TEXT_SIZE; upper bits are ignored. Block base word = index with the low $clog2(BLOCK_WORDS) bits cleared. Critical offset crit = the low bits of index.
- States: IDLE, T0_WAIT, GAP, BURST.
- IDLE: if ReadRequest is high at edge k, latch base and crit, set Busy=1, clear counters, and go to T0_WAIT. ReadRequest is ignored in every other state; there is no queueing.
- T0_WAIT: the delay counter counts 0..T0_DELAY. At the edge where it equals T0_DELAY, issue word 0 and go to GAP (TN_DELAY>0) or BURST. With T0_DELAY=0, word 0 is issued at edge k+1.
- Word j (j = 0..BLOCK_WORDS-1) has offset o_j = j in WRAP_MODE 0, or (crit + j) mod BLOCK_WORDS in WRAP_MODE 1.
- Issuing a word: DataIn = memory[base + o_j], WordIndex = o_j, and DataReady=1 for exactly one cycle.
- GAP: count TN_DELAY idle cycles with DataReady=0, then go to BURST. BURST: issue the next word, then return to GAP, or to BURST directly when TN_DELAY=0.
- Word j is issued at edge k + 1 + T0_DELAY + j*(TN_DELAY+1).
- On the edge that issues the last word, go to IDLE. Busy drops one cycle later, so Busy is still high during the last-word cycle. A new request can be accepted on the edge ending that cycle.
- DataIn and WordIndex hold their last values while DataReady=0.
- Counter widths: $clog2(max(T0_DELAY,TN_DELAY)+1) bits for the delay counter; $clog2(BLOCK_WORDS)+1 bits for the word counter. No overflow is permitted at any legal parameter value.

Decomposition:
- Package ucsbece154_mem_pkg holds:
  - the state enum (IDLE, T0_WAIT, GAP, BURST);
  - localparams WORD_BYTES=4 and OFFSET_BITS=$clog2(BLOCK_WORDS);
  - a function computing the burst offset from (crit, j, wrap).
- One natural sub-module: ucsbece154_burst_seq. It contains the FSM, the delay and word counters, and offset generation, and produces the issue strobe and offset. The top level holds the memory array and output registers.

Test Plan:
- Defaults, WRAP_MODE 0: request 0x24 at edge k -> DataIn 0x1B, 0x1C, 0x1D, 0x1E at edges k+41..k+44; WordIndex 0, 1, 2, 3; Busy low after k+44.
- WRAP_MODE 1, T0_DELAY 3: request 0x24 -> 0x1C, 0x1D, 0x1E, 0x1B with WordIndex 1, 2, 3, 0 at edges k+4..k+7.
- TN_DELAY 2, T0_DELAY 0: request 0x0 -> 0x13, 0x14, 0x15, 0x16 at edges k+1, k+4, k+7, k+10; DataReady low between them.
- ReadRequest held high continuously with T0_DELAY 0 -> exactly one burst per 5 cycles; a second request raised mid-burst is not accepted until IDLE.
- Address wrap: request 0x408 (word 258) with TEXT_SIZE 256 -> burst 0x13..0x16; WRAP_MODE 1 starts at 0x15.
- Async reset pulsed between clock edges during the second burst word -> DataReady, Busy, DataIn, and WordIndex are 0 immediately; no further words; a fresh request after reset completes a normal burst.
